// File: rtl/ps2_cmd_sequencer.sv
// Host-side PS/2 command sequencer: sends opcode/argument bytes through the byte
// transceiver, handles ACK/RESEND/BAT responses with retry and timeout, and forwards scan bytes.
module ps2_cmd_sequencer #(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic       req_has_arg,
    input  logic [7:0] req_arg,
    input  logic       req_wait_bat,
    output logic       done,
    output logic [1:0] status,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_sent,
    input  logic       tx_error,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] scan_data,
    output logic       scan_valid,
    output logic [3:0] dbg_state
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_SEND_OP       = 4'd1,
        S_WAIT_OP_SENT  = 4'd2,
        S_WAIT_OP_ACK   = 4'd3,
        S_SEND_ARG      = 4'd4,
        S_WAIT_ARG_SENT = 4'd5,
        S_WAIT_ARG_ACK  = 4'd6,
        S_WAIT_BAT      = 4'd7,
        S_FINISH        = 4'd8
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_cmd;
    logic          r_has_arg;
    logic [7:0]    r_arg;
    logic          r_wait_bat;
    logic [RW-1:0] r_retry;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_status;
    logic [7:0]    r_scan_data;
    logic          r_scan_valid;

    logic          w_accept;
    logic          w_status_set;
    logic [1:0]    w_status_val;
    logic          w_retry_inc;
    logic          w_retry_clr;
    logic          w_consumed;
    logic          w_expired;
    logic          w_timing;

    assign w_expired = (r_timer == TMAX);
    assign w_timing  = (r_state == S_WAIT_OP_ACK) || (r_state == S_WAIT_ARG_ACK) ||
                       (r_state == S_WAIT_BAT);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Request handshake: a request transfers on a cycle with req_valid && req_ready; req_ready is high only in IDLE.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_status_set = 1'b0;
        w_status_val = 2'd0;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        w_consumed   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SEND_OP;
                end
            end
            S_SEND_OP:  w_next = S_WAIT_OP_SENT;
            S_SEND_ARG: w_next = S_WAIT_ARG_SENT;
            S_WAIT_OP_SENT, S_WAIT_ARG_SENT: begin
                if (tx_error) begin
                    w_next       = S_FINISH;
                    w_status_set = 1'b1;
                    w_status_val = 2'd3;
                end else if (tx_sent) begin
                    w_next = (r_state == S_WAIT_OP_SENT) ? S_WAIT_OP_ACK : S_WAIT_ARG_ACK;
                end
            end
            S_WAIT_OP_ACK, S_WAIT_ARG_ACK: begin
                if (rx_valid && rx_data == 8'hFA) begin
                    w_consumed  = 1'b1;
                    w_retry_clr = 1'b1;
                    if (r_state == S_WAIT_OP_ACK && r_has_arg) begin
                        w_next = S_SEND_ARG;
                    end else if (r_wait_bat) begin
                        w_next = S_WAIT_BAT;
                    end else begin
                        w_next       = S_FINISH;
                        w_status_set = 1'b1;
                        w_status_val = 2'd0;
                    end
                end else if (rx_valid && rx_data == 8'hFE) begin
                    w_consumed = 1'b1;
                    // A resend repeats only the byte currently in flight.
                    if (r_retry < RMAX) begin
                        w_retry_inc = 1'b1;
                        w_next      = (r_state == S_WAIT_OP_ACK) ? S_SEND_OP : S_SEND_ARG;
                    end else begin
                        w_next       = S_FINISH;
                        w_status_set = 1'b1;
                        w_status_val = 2'd1;
                    end
                end else if (w_expired) begin
                    w_next       = S_FINISH;
                    w_status_set = 1'b1;
                    w_status_val = 2'd2;
                end
            end
            S_WAIT_BAT: begin
                if (rx_valid && (rx_data == 8'hAA || rx_data == 8'hFC)) begin
                    w_consumed   = 1'b1;
                    w_next       = S_FINISH;
                    w_status_set = 1'b1;
                    w_status_val = (rx_data == 8'hAA) ? 2'd0 : 2'd1;
                end else if (w_expired) begin
                    w_next       = S_FINISH;
                    w_status_set = 1'b1;
                    w_status_val = 2'd2;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_cmd        <= 8'd0;
            r_has_arg    <= 1'b0;
            r_arg        <= 8'd0;
            r_wait_bat   <= 1'b0;
            r_retry      <= '0;
            r_timer      <= '0;
            r_status     <= 2'd0;
            r_scan_data  <= 8'd0;
            r_scan_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd      <= req_cmd;
                r_has_arg  <= req_has_arg;
                r_arg      <= req_arg;
                r_wait_bat <= req_wait_bat;
                r_retry    <= '0;
                r_status   <= 2'd0;
            end else begin
                if (w_retry_clr)      r_retry <= '0;
                else if (w_retry_inc) r_retry <= r_retry + 1'b1;
                if (w_status_set)     r_status <= w_status_val;
            end
            // Timer restarts on every entry into a wait state; scan bytes do not restart it.
            if (w_timing && w_next == r_state) r_timer <= r_timer + 1'b1;
            else                               r_timer <= '0;
            r_scan_valid <= rx_valid && !w_consumed;
            if (rx_valid && !w_consumed) r_scan_data <= rx_data;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINISH);
    assign status     = r_status;
    assign tx_send    = (r_state == S_SEND_OP) || (r_state == S_SEND_ARG);
    assign tx_data    = (r_state == S_SEND_OP)  ? r_cmd :
                        (r_state == S_SEND_ARG) ? r_arg : 8'd0;
    assign scan_data  = r_scan_data;
    assign scan_valid = r_scan_valid;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: acts as the transceiver and keyboard, predicts transmitted
// bytes, final status and forwarded scan bytes from each command's reply plan.
module tb_ps2_cmd_sequencer;
    localparam int ACK_TIMEOUT = 16;
    localparam int MAX_RETRY   = 3;
    localparam int R_ACK = 0, R_RESEND = 1, R_SILENT = 2, R_TXERR = 3, R_TXBOTH = 4;
    localparam int B_AA = 0, B_FC = 1, B_SILENT = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_cmd = 8'd0;
    logic       req_has_arg = 1'b0;
    logic [7:0] req_arg = 8'd0;
    logic       req_wait_bat = 1'b0;
    logic       done;
    logic [1:0] status;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_sent = 1'b0;
    logic       tx_error = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic [3:0] dbg_state;

    logic [7:0] exp_tx_q[$];
    logic [1:0] exp_status_q[$];
    logic [7:0] exp_scan_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         plan[8];

    always #5 clk = ~clk;

    ps2_cmd_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .CLOCK_50(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_has_arg(req_has_arg), .req_arg(req_arg), .req_wait_bat(req_wait_bat),
        .done(done), .status(status), .busy(busy),
        .tx_data(tx_data), .tx_send(tx_send), .tx_sent(tx_sent), .tx_error(tx_error),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .scan_data(scan_data), .scan_valid(scan_valid), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the reply plan byte by byte and derive what must be sent and the final status.
    function automatic void model_cmd(input logic [7:0] cmd, input bit has_arg, input logic [7:0] arg,
                                      input bit wait_bat, input int rep[8], input int bat,
                                      output int ntx, output int st);
        int k, resends, r, nbytes;
        bit fin, acked;
        logic [7:0] b;
        k = 0; fin = 0; st = 0; ntx = 0;
        nbytes = has_arg ? 2 : 1;
        for (int i = 0; i < nbytes; i++) begin
            if (!fin) begin
                b = (i == 0) ? cmd : arg;
                resends = 0;
                acked = 0;
                while (!fin && !acked) begin
                    exp_tx_q.push_back(b);
                    ntx++;
                    r = (k < 8) ? rep[k] : R_SILENT;
                    k++;
                    if (r == R_ACK) acked = 1;
                    else if (r == R_RESEND) begin
                        if (resends == MAX_RETRY) begin st = 1; fin = 1; end
                        else resends++;
                    end else if (r == R_SILENT) begin st = 2; fin = 1; end
                    else begin st = 3; fin = 1; end
                end
            end
        end
        if (!fin && wait_bat) st = (bat == B_AA) ? 0 : (bat == B_FC) ? 1 : 2;
        exp_status_q.push_back(2'(st));
    endfunction

    function automatic logic [7:0] rand_scan();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255));
        while (v == 8'hFA || v == 8'hFE || v == 8'hAA || v == 8'hFC);
        return v;
    endfunction

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic do_gap(input int gap_sel, input logic [7:0] fixed);
        int g;
        logic [7:0] v;
        if (fixed != 8'd0) begin
            exp_scan_q.push_back(fixed);
            send_rx(fixed);
        end else begin
            g = (gap_sel >= 0) ? gap_sel : (($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 8));
            for (int i = 0; i < g; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    v = rand_scan();
                    exp_scan_q.push_back(v);
                    send_rx(v);
                end else step();
            end
        end
    endtask

    task automatic wait_timeout();
        int n;
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, ACK_TIMEOUT);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!req_ready && g < 100) begin
            step();
            g++;
        end
        if (!req_ready) flag("idle_wait_expired", int'(dbg_state));
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input bit has_arg, input logic [7:0] arg,
                           input bit wait_bat, input int rep[8], input int bat, input int gap_sel,
                           input logic [7:0] fixed_scan, input bit poke, input int lit_ntx,
                           input int lit_st);
        int ntx, st, idx, acks, nb, r, guard;
        bit fin;
        model_cmd(cmd, has_arg, arg, wait_bat, rep, bat, ntx, st);
        if (lit_ntx >= 0) begin
            chk("model_tx_count", ntx, lit_ntx);
            chk("model_status", st, lit_st);
        end
        wait_idle();
        req_cmd = cmd; req_has_arg = has_arg; req_arg = arg; req_wait_bat = wait_bat;
        req_valid = 1'b1;
        step();
        if (poke) begin
            req_cmd = 8'($urandom_range(0, 255));
            req_has_arg = 1'($urandom_range(0, 1));
        end else req_valid = 1'b0;
        idx = 0; acks = 0; nb = has_arg ? 2 : 1; fin = 0; guard = 0;
        while (!fin) begin
            if (done) begin
                fin = 1;
                req_valid = 1'b0;
            end else if (guard > 300) begin
                flag("cmd_hang", int'(dbg_state));
                fin = 1;
                req_valid = 1'b0;
            end else if (tx_send) begin
                guard++;
                r = (idx < 8) ? rep[idx] : R_SILENT;
                idx++;
                repeat ($urandom_range(1, 3)) step();
                if (r == R_TXERR || r == R_TXBOTH) begin
                    tx_error = 1'b1;
                    tx_sent = (r == R_TXBOTH);
                    step();
                    tx_error = 1'b0;
                    tx_sent = 1'b0;
                end else begin
                    tx_sent = 1'b1;
                    step();
                    tx_sent = 1'b0;
                    if (r == R_SILENT) wait_timeout();
                    else begin
                        do_gap(gap_sel, 8'd0);
                        send_rx((r == R_ACK) ? 8'hFA : 8'hFE);
                        if (r == R_ACK) begin
                            acks++;
                            if (acks == nb && wait_bat) begin
                                if (bat == B_SILENT) wait_timeout();
                                else begin
                                    do_gap(gap_sel, fixed_scan);
                                    send_rx((bat == B_AA) ? 8'hAA : 8'hFC);
                                end
                            end
                        end
                    end
                end
            end else begin
                step();
                guard++;
            end
        end
    endtask

    // Compare process: checks outputs on every falling edge against the expected queues.
    initial begin
        bit prev_accept, prev_done;
        logic [1:0] last_status, e;
        prev_accept = 0; prev_done = 0; last_status = 2'd0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_accept = 0; prev_done = 0; last_status = 2'd0;
            end else begin
                chk("ready_vs_busy", int'(req_ready), int'(!busy));
                if (prev_accept) chk("send_after_accept", int'(tx_send), 1);
                if (prev_done) chk("ready_after_done", int'(req_ready), 1);
                if (tx_send) begin
                    if (exp_tx_q.size() > 0) chk("tx_byte", int'(tx_data), int'(exp_tx_q.pop_front()));
                    else flag("tx_unexpected", int'(tx_data));
                end
                if (done) begin
                    if (exp_status_q.size() > 0) begin
                        e = exp_status_q.pop_front();
                        chk("done_status", int'(status), int'(e));
                        last_status = e;
                    end else flag("done_unexpected", int'(status));
                end else if (req_ready) chk("status_hold", int'(status), int'(last_status));
                if (scan_valid) begin
                    if (exp_scan_q.size() > 0) chk("scan_byte", int'(scan_data), int'(exp_scan_q.pop_front()));
                    else flag("scan_unexpected", int'(scan_data));
                end
                prev_accept = req_valid && req_ready;
                prev_done = done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, bat;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_status", int'(status), 0);
        chk("rst_tx_send", int'(tx_send), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_scan_valid", int'(scan_valid), 0);
        chk("rst_scan_data", int'(scan_data), 0);
        chk("rst_dbg_state_idle", int'(dbg_state), 0);
        resetn = 1'b1;
        step();

        plan = '{R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK};
        run_cmd(8'hED, 1, 8'h07, 0, plan, B_AA, -1, 8'd0, 0, 2, 0);
        plan = '{R_RESEND, R_RESEND, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK};
        run_cmd(8'hF4, 0, 8'h00, 0, plan, B_AA, -1, 8'd0, 0, 3, 0);
        plan = '{R_RESEND, R_RESEND, R_RESEND, R_RESEND, R_RESEND, R_RESEND, R_RESEND, R_RESEND};
        run_cmd(8'hF4, 0, 8'h00, 0, plan, B_AA, -1, 8'd0, 0, 4, 1);
        plan = '{R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK};
        run_cmd(8'hFF, 0, 8'h00, 1, plan, B_AA, 0, 8'h1C, 0, 1, 0);
        run_cmd(8'hFF, 0, 8'h00, 1, plan, B_FC, 0, 8'h1C, 0, 1, 1);
        // Responses landing in the final cycle of the wait window.
        run_cmd(8'hFF, 0, 8'h00, 1, plan, B_AA, 15, 8'd0, 0, 1, 0);
        plan = '{R_SILENT, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK};
        run_cmd(8'hF5, 0, 8'h00, 0, plan, B_AA, -1, 8'd0, 0, 1, 2);
        plan = '{R_TXBOTH, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK, R_ACK};
        run_cmd(8'hF3, 1, 8'h20, 0, plan, B_AA, -1, 8'd0, 0, 1, 3);

        step();
        wait_idle();
        exp_scan_q.push_back(8'h1C);
        exp_scan_q.push_back(8'hF0);
        exp_scan_q.push_back(8'hFA);
        rx_data = 8'h1C; rx_valid = 1'b1;
        step();
        chk("idle_scan0_valid", int'(scan_valid), 1);
        chk("idle_scan0_data", int'(scan_data), 8'h1C);
        rx_data = 8'hF0;
        step();
        chk("idle_scan1_data", int'(scan_data), 8'hF0);
        rx_data = 8'hFA;
        step();
        chk("idle_scan2_data", int'(scan_data), 8'hFA);
        rx_valid = 1'b0;
        step();
        chk("idle_scan_quiet", int'(scan_valid), 0);

        exp_tx_q.push_back(8'hED);
        exp_tx_q.push_back(8'h07);
        req_cmd = 8'hED; req_has_arg = 1'b1; req_arg = 8'h07; req_wait_bat = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        tx_sent = 1'b1; step(); tx_sent = 1'b0;
        send_rx(8'hFA);
        step();
        tx_sent = 1'b1; step(); tx_sent = 1'b0;
        step();
        step();
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_req_ready", int'(req_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_tx_send", int'(tx_send), 0);
        chk("mid_rst_tx_data", int'(tx_data), 0);
        chk("mid_rst_scan_valid", int'(scan_valid), 0);
        chk("mid_rst_scan_data", int'(scan_data), 0);
        chk("mid_rst_status", int'(status), 0);
        step();
        step();
        resetn = 1'b1;
        repeat (20) step();
        chk("mid_rst_tx_drained", exp_tx_q.size(), 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) begin
                w = $urandom_range(0, 99);
                plan[i] = (w < 55) ? R_ACK : (w < 85) ? R_RESEND : (w < 92) ? R_TXERR :
                          (w < 95) ? R_TXBOTH : R_SILENT;
            end
            w = $urandom_range(0, 99);
            bat = (w < 45) ? B_AA : (w < 90) ? B_FC : B_SILENT;
            run_cmd(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), plan, bat, -1, 8'd0, ($urandom_range(0, 3) == 0), -1, -1);
            step();
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    w = $urandom_range(0, 255);
                    exp_scan_q.push_back(8'(w));
                    send_rx(8'(w));
                end
            end
        end

        repeat (5) step();
        chk("final_tx_queue_empty", exp_tx_q.size(), 0);
        chk("final_status_queue_empty", exp_status_q.size(), 0);
        chk("final_scan_queue_empty", exp_scan_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
- Host-side command controller for the PS/2 keyboard path.
- Accepts one command request at a time (opcode, optional argument byte, optional wait for the self-test result).
- Drives the byte-level PS/2 transceiver's send handshake, consumes the device's ACK (0xFA), RESEND (0xFE) and BAT (0xAA/0xFC) responses, retries and times out.
- Forwards every other received byte as scan data to the keyboard-decoding logic.

Parameters:
- ACK_TIMEOUT, 1000000: clock cycles (20 ms at 50 MHz) to wait for any expected response byte.
- MAX_RETRY, 3: maximum resends of one byte after 0xFE before giving up.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  command request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_cmd  in  8  opcode byte
- req_has_arg  in  1  send req_arg after opcode ACK
- req_arg  in  8  argument byte
- req_wait_bat  in  1  after final ACK, wait for BAT result
- done  out  1  one-cycle completion pulse
- status  out  2  0 OK, 1 NAK/BAT-fail, 2 timeout, 3 transmit error
- busy  out  1  high in every state except IDLE
- tx_data  out  8  byte to transmit
- tx_send  out  1  one-cycle send strobe to transceiver
- tx_sent  in  1  transceiver finished sending byte
- tx_error  in  1  transceiver send failure/timeout
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid, one cycle
- scan_data  out  8  forwarded non-response byte
- scan_valid  out  1  one-cycle strobe for scan_data

Behaviour:
- Reset (async, resetn=0): state IDLE, req_ready=1, busy=0, done=0, status=0, tx_send=0, tx_data=0, scan_valid=0, scan_data=0, retry count=0, timer=0; all latched request fields cleared.
- Reset mid-operation: abort immediately, no done pulse, no further tx_send.
- IDLE: on accept, latch cmd/has_arg/arg/wait_bat, clear retry count and status; go to SEND_OP.
- SEND_OP (1 cycle): tx_send=1, tx_data=cmd. tx_send asserts the cycle after accept. Go to WAIT_OP_SENT.
- WAIT_OP_SENT:
  - tx_error -> FINISH status 3. tx_error wins over a simultaneous tx_sent.
  - tx_sent -> WAIT_OP_ACK, timer cleared.
- WAIT_OP_ACK, on rx_valid:
  - 0xFA -> SEND_ARG if has_arg, else WAIT_BAT if wait_bat, else FINISH status 0. Retry count cleared.
  - 0xFE -> if retry count < MAX_RETRY: increment it and go to SEND_OP (same byte). Otherwise FINISH status 1.
  - Any other byte -> forwarded on scan_data/scan_valid next cycle; state unchanged; timer not cleared.
- Timer (all three wait states): counts every cycle in WAIT_*_ACK and WAIT_BAT. At ACK_TIMEOUT-1 with no qualifying byte -> FINISH status 2. A response byte in the expiry cycle takes precedence over the timeout.
- SEND_ARG / WAIT_ARG_SENT / WAIT_ARG_ACK: identical rules with tx_data=arg. Retries resend arg only, never the opcode. After ACK: WAIT_BAT if wait_bat, else FINISH status 0.
- WAIT_BAT, on rx_valid:
  - 0xAA -> FINISH status 0.
  - 0xFC -> FINISH status 1.
  - Other bytes -> forwarded as scan data.
- FINISH (1 cycle): done=1 and status valid. status holds until the next accept. Then IDLE; req_ready rises the cycle after done.
- IDLE rx forwarding: in IDLE every rx_valid byte (including 0xFA/0xFE/0xAA) is forwarded as scan data, one cycle later.
- scan_valid is registered: exactly one pulse per forwarded byte. Bytes consumed as responses never appear on scan_valid.
- Retry count is 2 bits wide (sized to MAX_RETRY) and saturates at MAX_RETRY.
- A request held on req_valid during busy is not accepted; accepted only when back in IDLE.

Test Plan:
- Set LEDs: req_cmd=0xED, has_arg=1, arg=0x07; model returns tx_sent then 0xFA after each byte -> tx_send with 0xED the cycle after accept, then 0x07; single done, status=0.
- Resend: req_cmd=0xF4, no arg; model replies 0xFE twice then 0xFA -> exactly three tx_send pulses all 0xF4; done with status=0.
- Retry exhaustion: model always replies 0xFE (MAX_RETRY=3) -> 4 tx_send pulses; done with status=1; req_ready=1 the following cycle.
- Reset with BAT: req_cmd=0xFF, wait_bat=1; replies 0xFA, then scan byte 0x1C, then 0xAA -> one scan_valid with 0x1C; done status=0. Repeat with 0xFC -> status=1.
- Timeout and tx error (ACK_TIMEOUT=16): no reply after tx_sent -> done status=2 exactly 16 cycles after entering WAIT_OP_ACK. tx_error and tx_sent in the same cycle -> status=3.
- Async reset: assert resetn=0 in WAIT_ARG_ACK -> all outputs return to reset values that cycle; no done pulse. Bytes 0x1C and 0xF0 sent while idle -> both forwarded in order.
